alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer_if.sv | 49 ++++
 rtl/alu_sequencer.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/alu_sequencer_if.sv
// Instruction, ALU operand and response bus of the ALU sequencer.
// slave is the sequencer side, master is its environment.
interface alu_sequencer_if;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_op;
    logic [15:0] alu_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [1:0]  rsp_rd;
    logic        rsp_err;
    logic [15:0] done_count;

    modport master (
        output instr,
        output instr_valid,
        output alu_result,
        output rsp_ready,
        input  instr_ready,
        input  alu_a,
        input  alu_b,
        input  alu_op,
        input  rsp_valid,
        input  rsp_data,
        input  rsp_rd,
        input  rsp_err,
        input  done_count
    );

    modport slave (
        input  instr,
        input  instr_valid,
        input  alu_result,
        input  rsp_ready,
        output instr_ready,
        output alu_a,
        output alu_b,
        output alu_op,
        output rsp_valid,
        output rsp_data,
        output rsp_rd,
        output rsp_err,
        output done_count
    );
endinterface

// File: rtl/alu_sequencer.sv
// Sequences 16-bit instructions through an external combinational ALU
// over a four-entry register file, one instruction in flight at a time.
module alu_sequencer #(
    parameter int unsigned ALU_WAIT = 0
) (
    input  logic           clk,
    input  logic           reset,
    alu_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_e;

    localparam logic [3:0] WAIT_INIT = 4'(ALU_WAIT);

    state_e      state_q, state_d;
    logic [15:0] instr_q, instr_d;
    logic [3:0]  wait_q, wait_d;
    logic [15:0] regs_q [4];
    logic [15:0] regs_d [4];
    logic [15:0] rsp_data_q, rsp_data_d;
    logic [1:0]  rsp_rd_q, rsp_rd_d;
    logic        rsp_err_q, rsp_err_d;
    logic [15:0] done_q, done_d;

    logic        instr_ready;
    logic        rsp_valid;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_op;

    logic [2:0]  opc;
    logic [1:0]  rd;
    logic [1:0]  ra;
    logic [1:0]  rb;
    logic [7:0]  imm;

    assign opc = instr_q[15:13];
    assign rd  = instr_q[12:11];
    assign ra  = instr_q[10:9];
    assign rb  = instr_q[8:7];
    assign imm = instr_q[7:0];

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        wait_d      = wait_q;
        regs_d      = regs_q;
        rsp_data_d  = rsp_data_q;
        rsp_rd_d    = rsp_rd_q;
        rsp_err_d   = rsp_err_q;
        done_d      = done_q;
        instr_ready = 1'b0;
        rsp_valid   = 1'b0;
        alu_a       = '0;
        alu_b       = '0;
        alu_op      = '0;

        unique case (state_q)
            IDLE: begin
                instr_ready = 1'b1;
                if (bus.instr_valid) begin
                    instr_d = bus.instr;
                    wait_d  = WAIT_INIT;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                unique case (1'b1)
                    (opc[2] == 1'b0): begin
                        alu_a  = regs_q[ra];
                        alu_b  = regs_q[rb];
                        alu_op = {2'b00, opc[1:0]};
                    end
                    (opc == 3'd4): begin
                        alu_a  = {8'h00, imm};
                        alu_op = 4'd3;
                    end
                    default: ;
                endcase
                // regs_q still holds pre-write values, so rd==ra/rb reads old data
                if (wait_q == 4'd0) begin
                    rsp_data_d = bus.alu_result;
                    rsp_rd_d   = rd;
                    rsp_err_d  = (opc >= 3'd5);
                    if (opc <= 3'd4) begin
                        regs_d[rd] = bus.alu_result;
                    end
                    state_d = RESP;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    done_d  = done_q + 16'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (reset) begin
            instr_ready = 1'b0;
            rsp_valid   = 1'b0;
            alu_a       = '0;
            alu_b       = '0;
            alu_op      = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            instr_q    <= '0;
            wait_q     <= '0;
            regs_q     <= '{default: '0};
            rsp_data_q <= '0;
            rsp_rd_q   <= '0;
            rsp_err_q  <= 1'b0;
            done_q     <= '0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            wait_q     <= wait_d;
            regs_q     <= regs_d;
            rsp_data_q <= rsp_data_d;
            rsp_rd_q   <= rsp_rd_d;
            rsp_err_q  <= rsp_err_d;
            done_q     <= done_d;
        end
    end

    assign bus.instr_ready = instr_ready;
    assign bus.rsp_valid   = rsp_valid;
    assign bus.alu_a       = alu_a;
    assign bus.alu_b       = alu_b;
    assign bus.alu_op      = alu_op;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_rd      = rsp_rd_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.done_count  = done_q;
endmodule
